// File: rtl/fader_pkg.sv
// Shared constants and ramp state type for the output fader.
// The gain format is unsigned Q1.15, so unity is the top bit alone.
package fader_pkg;

  localparam logic [15:0] GAIN_UNITY        = 16'h8000;
  localparam int          DEFAULT_RAMP_STEP = 32'sd16;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD      = 2'd3
  } fader_state_t;

endpackage

// File: rtl/gain_ramp.sv
// Frame-strobed gain ramp: clamps the requested gain, slews toward it by a
// fixed step per frame without overshoot, and tracks the ramp state.
module gain_ramp
  import fader_pkg::*;
#(
  parameter int GAINBITS  = 16,
  parameter int RAMP_STEP = DEFAULT_RAMP_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strobe,
  input  logic [GAINBITS-1:0] gain_target,
  input  logic                mute,
  output logic [GAINBITS-1:0] gain,
  output fader_state_t        state
);

  localparam logic [GAINBITS-1:0] UNITY  = GAINBITS'(GAIN_UNITY);
  localparam logic [GAINBITS-1:0] STEP_N = GAINBITS'(RAMP_STEP);
  localparam logic [GAINBITS:0]   STEP_W = (GAINBITS + 1)'(RAMP_STEP);
  localparam logic [GAINBITS-1:0] ZERO   = {GAINBITS{1'b0}};

  logic [GAINBITS-1:0] tgt_s;
  logic [GAINBITS-1:0] gain_r;
  logic [GAINBITS-1:0] gain_nxt_s;
  logic [GAINBITS:0]   up_sum_s;
  fader_state_t        state_r;
  fader_state_t        state_nxt_s;

  // Effective target: mute overrides, otherwise clamp to unity.
  always_comb begin
    tgt_s = ZERO;
    if (mute) begin
      tgt_s = ZERO;
    end else if (gain_target > UNITY) begin
      tgt_s = UNITY;
    end else begin
      tgt_s = gain_target;
    end
  end

  // Next gain and next state; the distance is checked before stepping down.
  always_comb begin
    up_sum_s    = {1'b0, gain_r} + STEP_W;
    gain_nxt_s  = gain_r;
    state_nxt_s = state_r;
    if (gain_r < tgt_s) begin
      if (up_sum_s > {1'b0, tgt_s}) begin
        gain_nxt_s = tgt_s;
      end else begin
        gain_nxt_s = up_sum_s[GAINBITS-1:0];
      end
    end else if (gain_r > tgt_s) begin
      if ((gain_r - tgt_s) <= STEP_N) begin
        gain_nxt_s = tgt_s;
      end else begin
        gain_nxt_s = gain_r - STEP_N;
      end
    end else begin
      gain_nxt_s = gain_r;
    end

    if (gain_nxt_s < tgt_s) begin
      state_nxt_s = RAMP_UP;
    end else if (gain_nxt_s > tgt_s) begin
      state_nxt_s = RAMP_DOWN;
    end else if (tgt_s == ZERO) begin
      state_nxt_s = MUTED;
    end else begin
      state_nxt_s = HOLD;
    end
  end

  // Gain and state advance only on the frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_r  <= ZERO;
      state_r <= MUTED;
    end else if (strobe) begin
      gain_r  <= gain_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign gain  = gain_r;
  assign state = state_r;

endmodule

// File: rtl/output_fader.sv
// Click-free master volume/mute: detects the frame start from lrclk, ramps
// the gain once per frame and scales both channels through a 3-stage pipe.
module output_fader
  import fader_pkg::*;
#(
  parameter int BITSIZE   = 16,
  parameter int GAINBITS  = 16,
  parameter int RAMP_STEP = DEFAULT_RAMP_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lrclk,
  input  logic [BITSIZE-1:0]  in_l,
  input  logic [BITSIZE-1:0]  in_r,
  input  logic [GAINBITS-1:0] gain_target,
  input  logic                mute,
  output logic [BITSIZE-1:0]  out_l,
  output logic [BITSIZE-1:0]  out_r,
  output logic [GAINBITS-1:0] gain_now,
  output logic                muted
);

  localparam int PW    = BITSIZE + GAINBITS + 1;
  localparam int SHIFT = GAINBITS - 1;

  logic                      lr_q_r;
  logic                      strobe_s;
  logic [GAINBITS-1:0]       gain_s;
  fader_state_t              state_s;
  logic signed [BITSIZE-1:0] s1_l_r;
  logic signed [BITSIZE-1:0] s1_r_r;
  logic [GAINBITS-1:0]       s1_gain_r;
  logic signed [PW-1:0]      s2_l_r;
  logic signed [PW-1:0]      s2_r_r;
  logic [BITSIZE-1:0]        out_l_r;
  logic [BITSIZE-1:0]        out_r_r;

  // lrclk history; a falling edge marks the start of the left word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_q_r <= 1'b0;
    end else begin
      lr_q_r <= lrclk;
    end
  end

  assign strobe_s = lr_q_r & ~lrclk;

  gain_ramp #(
    .GAINBITS  (GAINBITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .clk         (clk),
    .rst_n       (rst_n),
    .strobe      (strobe_s),
    .gain_target (gain_target),
    .mute        (mute),
    .gain        (gain_s),
    .state       (state_s)
  );

  // Stage 1: capture samples with the gain in force before this frame's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_l_r    <= {BITSIZE{1'b0}};
      s1_r_r    <= {BITSIZE{1'b0}};
      s1_gain_r <= {GAINBITS{1'b0}};
    end else if (strobe_s) begin
      s1_l_r    <= $signed(in_l);
      s1_r_r    <= $signed(in_r);
      s1_gain_r <= gain_s;
    end
  end

  // Stage 2: signed product against the zero-extended unsigned gain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_l_r <= {PW{1'b0}};
      s2_r_r <= {PW{1'b0}};
    end else begin
      s2_l_r <= PW'(s1_l_r) * PW'($signed({1'b0, s1_gain_r}));
      s2_r_r <= PW'(s1_r_r) * PW'($signed({1'b0, s1_gain_r}));
    end
  end

  // Stage 3: floor back to sample width; gain <= unity keeps it in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_l_r <= {BITSIZE{1'b0}};
      out_r_r <= {BITSIZE{1'b0}};
    end else begin
      out_l_r <= BITSIZE'(s2_l_r >>> SHIFT);
      out_r_r <= BITSIZE'(s2_r_r >>> SHIFT);
    end
  end

  assign out_l    = out_l_r;
  assign out_r    = out_r_r;
  assign gain_now = gain_s;
  assign muted    = (state_s == MUTED);

endmodule

// File: tb/tb_output_fader.sv
// Directed bench for output_fader: a frame-level arithmetic model is compared
// every cycle, plus hand-computed literal expectations at key points.
module tb_output_fader;
  import fader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrclk = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] in_l = 16'h4000;
  logic [15:0] in_r = 16'hE000;
  logic [15:0] gain_target = 16'h8000;
  logic [15:0] out_l, out_r, gain_now;
  logic        muted;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int due;
    int l;
    int r;
    int il;
    int ir;
  } pend_t;

  pend_t pend[$];
  int m_gain = 0, m_prev = 0, cyc = 0;
  int exp_l = 0, exp_r = 0, exp_muted = 1, exp_in_l = 0, exp_in_r = 0;

  always #5 clk = ~clk;

  output_fader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lrclk       (lrclk),
    .in_l        (in_l),
    .in_r        (in_r),
    .gain_target (gain_target),
    .mute        (mute),
    .out_l       (out_l),
    .out_r       (out_r),
    .gain_now    (gain_now),
    .muted       (muted)
  );

  function automatic int scale(input int a, input int g);
    int p, q;
    p = a * g;
    q = p / 32768;
    if (p < 0 && q * 32768 != p) q = q - 1;
    return q;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: one gain step per lrclk falling edge, outputs 3 edges later.
  initial forever begin
    int t;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_gain = 0; m_prev = 0; cyc = 0;
      exp_l = 0; exp_r = 0; exp_muted = 1; exp_in_l = 0; exp_in_r = 0;
      pend.delete();
    end else begin
      cyc++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_l = pend[0].l; exp_r = pend[0].r;
        exp_in_l = pend[0].il; exp_in_r = pend[0].ir;
        void'(pend.pop_front());
      end
      if (m_prev == 1 && lrclk == 1'b0) begin
        t = mute ? 0 : ((int'(gain_target) > 32768) ? 32768 : int'(gain_target));
        pend.push_back('{cyc + 2,
                         scale(int'($signed(in_l)), m_gain),
                         scale(int'($signed(in_r)), m_gain),
                         int'($signed(in_l)), int'($signed(in_r))});
        if (m_gain < t) m_gain = (m_gain + 16 > t) ? t : m_gain + 16;
        else if (m_gain > t) m_gain = (m_gain - 16 < t) ? t : m_gain - 16;
        exp_muted = (m_gain == 0 && t == 0) ? 1 : 0;
      end
      m_prev = int'(lrclk);
    end
  end

  // Per-cycle comparison against the model while out of reset.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("gain_now", int'(gain_now), m_gain);
      check("muted", int'(muted), exp_muted);
      check("out_l", int'($signed(out_l)), exp_l);
      check("out_r", int'($signed(out_r)), exp_r);
      check("mag_l", (iabs(int'($signed(out_l))) <= iabs(exp_in_l)) ? 1 : 0, 1);
      check("mag_r", (iabs(int'($signed(out_r))) <= iabs(exp_in_r)) ? 1 : 0, 1);
    end
  end

  task automatic frame(input int n);
    for (int f = 0; f < n; f++) begin
      lrclk = 1'b1;
      repeat (3) @(negedge clk);
      lrclk = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_gain", int'(gain_now), 32'd0);
    check("rst_out_l", int'(out_l), 32'd0);
    check("rst_out_r", int'(out_r), 32'd0);
    check("rst_muted", int'(muted), 32'd1);
    rst_n = 1'b1;

    // Fade-in from power-up silence.
    frame(1);
    check("fadein_first_out", int'(out_l), 32'h0000);
    check("fadein_first_gain", int'(gain_now), 32'h0010);
    check("fadein_state", int'(dut.state_s), int'(RAMP_UP));
    frame(2047);
    check("fadein_gain", int'(gain_now), 32'h8000);
    check("fadein_hold", int'(dut.state_s), int'(HOLD));
    frame(1);
    check("unity_out_l", int'(out_l), 32'h4000);
    check("unity_out_r", int'(out_r), 32'hE000);

    // Step down to half gain.
    gain_target = 16'h4000;
    frame(1024);
    check("half_gain", int'(gain_now), 32'h4000);
    frame(1);
    check("half_out_l", int'(out_l), 32'h2000);
    check("half_out_r", int'(out_r), 32'hF000);

    // Back to unity, then mute.
    gain_target = 16'h8000;
    frame(1024);
    check("reunity_gain", int'(gain_now), 32'h8000);
    mute = 1'b1;
    frame(2047);
    check("mute_almost", int'(muted), 32'd0);
    frame(1);
    check("mute_gain", int'(gain_now), 32'd0);
    check("mute_flag", int'(muted), 32'd1);
    frame(1);
    check("mute_out_l", int'(out_l), 32'd0);

    // Unmute, mute-wins collision, and reversal at 0x2000.
    mute = 1'b0;
    frame(512);
    check("mid_gain", int'(gain_now), 32'h2000);
    mute = 1'b1;
    gain_target = 16'h7000;
    frame(1);
    check("mute_wins", int'(gain_now), 32'h1FF0);
    check("down_state", int'(dut.state_s), int'(RAMP_DOWN));
    mute = 1'b0;
    frame(1);
    check("reverse_gain", int'(gain_now), 32'h2000);
    check("reverse_state", int'(dut.state_s), int'(RAMP_UP));

    // Clamp and extreme samples.
    gain_target = 16'hFFFF;
    frame(1536);
    check("clamp_gain", int'(gain_now), 32'h8000);
    in_l = 16'h8000;
    in_r = 16'h7FFF;
    frame(1);
    check("clamp_no_overshoot", int'(gain_now), 32'h8000);
    check("neg_full", int'(out_l), 32'h8000);
    check("pos_full", int'(out_r), 32'h7FFF);

    // Exact 3-clock latency after the lrclk falling edge.
    in_l = 16'h1234;
    lrclk = 1'b1;
    repeat (3) @(negedge clk);
    lrclk = 1'b0;
    @(negedge clk);
    check("lat_edge1", int'(out_l), 32'h8000);
    @(negedge clk);
    check("lat_edge2", int'(out_l), 32'h8000);
    @(negedge clk);
    check("lat_edge3", int'(out_l), 32'h1234);

    // Asynchronous reset mid-operation, released on an lrclk falling edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_gain", int'(gain_now), 32'd0);
    check("async_out_l", int'(out_l), 32'd0);
    check("async_out_r", int'(out_r), 32'd0);
    check("async_muted", int'(muted), 32'd1);
    @(negedge clk);
    lrclk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lrclk = 1'b0;
    repeat (3) @(negedge clk);
    check("release_edge_ignored", int'(gain_now), 32'd0);

    // Target that is not a multiple of the step.
    gain_target = 16'h0005;
    frame(1);
    check("small_gain", int'(gain_now), 32'h0005);
    check("small_hold", int'(dut.state_s), int'(HOLD));
    frame(1);
    check("small_stable", int'(gain_now), 32'h0005);
    gain_target = 16'h0000;
    frame(1);
    check("zero_gain", int'(gain_now), 32'd0);
    check("zero_muted", int'(muted), 32'd1);

    // Stall: static lrclk freezes gain and outputs.
    gain_target = 16'h8000;
    in_l = 16'h4000;
    frame(10);
    check("pre_stall_gain", int'(gain_now), 32'h00A0);
    check("pre_stall_out", int'(out_l), 32'h0048);
    lrclk = 1'b1;
    in_l = 16'h7FFF;
    repeat (1000) @(negedge clk);
    check("stall_gain", int'(gain_now), 32'h00A0);
    check("stall_out", int'(out_l), 32'h0048);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/output_fader.md
Name: output_fader

Overview:
- Click-free master volume and mute stage between the routing matrix outputs (out_l/out_r) and the overdrive/i2s_tx output path.
- Runs on the codec bit clock. Detects each stereo frame from lrclk.
- Ramps a Q1.15 gain toward a CPU-written target by a fixed step per frame, then scales both channels.
- Powers up silent and fades in, which removes the start-up pop.

Parameters:
- BITSIZE, 16, sample width in bits; signed two's complement.
- GAINBITS, 16, gain width in bits; unsigned Q1.15; unity = 0x8000.
- RAMP_STEP, 16, gain change per frame. Full-scale ramp is 2048 frames, about 43 ms at 48 kHz.

Ports:
- clk  in  1  codec bit clock (BCLK); all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lrclk  in  1  DAC word clock, synchronous to clk.
- in_l  in  BITSIZE  left sample, signed.
- in_r  in  BITSIZE  right sample, signed.
- gain_target  in  GAINBITS  requested gain, Q1.15; values above 0x8000 are clamped to 0x8000.
- mute  in  1  level; when high, forces the effective target to 0.
- out_l  out  BITSIZE  scaled left sample, signed.
- out_r  out  BITSIZE  scaled right sample, signed.
- gain_now  out  GAINBITS  current ramped gain.
- muted  out  1  high while gain_now == 0 and the effective target == 0.

Behaviour:
- Reset (async, rst_n low):
  - gain_now = 0, out_l = out_r = 0, all pipeline registers = 0.
  - lrclk history register = 0; FSM = MUTED; muted = 1.
  - Takes effect immediately, including mid-ramp.
- Frame strobe:
  - lrclk is registered once (lr_q).
  - strobe = lr_q & ~lrclk, i.e. falling edge = start of the left word.
  - Exactly one strobe per frame. No strobe while lrclk is static; gain and outputs then hold.
- Effective target: tgt = mute ? 0 : min(gain_target, 0x8000). Re-evaluated at every strobe.
- Gain update, on strobe only:
  - If gain < tgt: gain = min(gain + RAMP_STEP, tgt).
  - If gain > tgt: gain = max(gain - RAMP_STEP, tgt). Compare before subtracting, so no underflow.
  - Otherwise gain is unchanged.
  - A target change mid-ramp reverses direction at the next strobe.
- FSM (inside gain_ramp), evaluated on strobe after the update:
  - MUTED: gain == 0 and tgt == 0.
  - RAMP_UP: gain < tgt.
  - RAMP_DOWN: gain > tgt.
  - HOLD: gain == tgt != 0.
  - muted output = (state == MUTED).
  - Any state may go to any state on a target/mute change.
- Datapath pipeline (3 clk):
  - S1, on strobe: capture in_l, in_r, and the pre-update gain.
  - S2: signed product = in × {1'b0, gain}, 2*BITSIZE+1 bits wide.
  - S3: out = product >>> 15, truncated (floor), registered.
  - out_l/out_r change exactly 3 clk after the strobe cycle and hold until the next frame.
- Width rule:
  - With gain ≤ 0x8000 the result always fits BITSIZE, so no saturation logic.
  - Verification asserts |out| ≤ |in|.
- Simultaneous events:
  - mute and a gain_target change in the same strobe: mute wins.
  - Reset deassert coincident with an lrclk edge: that edge is ignored, because lr_q was 0.

Decomposition:
- Shared package fader_pkg holds:
  - GAIN_UNITY = 0x8000;
  - the state enum {MUTED, RAMP_UP, RAMP_DOWN, HOLD};
  - the default RAMP_STEP.
- One sub-module, gain_ramp: the strobe-driven gain register, the clamp, and the FSM; outputs gain and state.
- The top level holds lrclk edge detection and the 3-stage multiply pipeline.

Test Plan:
- Fade-in: release rst_n with gain_target = 0x8000, mute = 0, in_l = 0x4000. First frame gives out_l = 0x0000. gain_now reaches 0x8000 after 2048 strobes, after which out_l = 0x4000 and state = HOLD.
- Step down: from HOLD at 0x8000, write 0x4000. gain_now = 0x4000 after exactly 1024 strobes; in_l = 0x4000 → out_l = 0x2000; out_r tracks in_r identically.
- Mute/unmute: from unity, mute = 1. muted rises after 2048 strobes and out = 0. mute = 0 at gain 0x2000 mid-fade reverses to RAMP_UP at the next strobe.
- Clamp/extremes: gain_target = 0xFFFF gives gain_now 0x8000. in = 0x8000 (-32768) → out 0x8000; in = 0x7FFF → out 0x7FFF. Latency is exactly 3 clk after the lrclk falling edge.
- Non-multiple target: from 0, target 0x0005 gives gain_now = 0x0005 after 1 strobe with no overshoot. Target 0x0000 then gives 0 after 1 strobe and muted = 1.
- Reset/stall:
  - rst_n low mid-ramp clears out_l, out_r and gain_now asynchronously, before the next clk edge.
  - With lrclk held static for 1000 clk, gain_now and the outputs stay unchanged.
